// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl: arbitrates BTB predictions and ID fixes into one IF redirect, then drains squashed slots.
// Optional redirect statistics are built only when REDIRECT_STATS_EN is defined.
module pc_redirect_ctrl #(
   parameter int DRAIN_CYCLES = 7
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        STALL,
   input  logic        pred_req_IF,
   input  logic [31:0] pred_pc_IF,
   input  logic        fix_req_ID,
   input  logic [31:0] fix_pc_ID,
   output logic        Request_Alt_PC_OUT,
   output logic [31:0] Alt_PC_OUT,
   output logic        FLUSH_OUT,
   output logic        busy,
   output logic [31:0] pred_count,
   output logic [31:0] fix_count
);
   localparam int CW = $clog2(DRAIN_CYCLES + 1);
   typedef enum logic [1:0] {IDLE, HOLD, DRAIN} state_t;
   state_t state, state_n;
   logic lat_v, lat_v_n, lat_fix, lat_fix_n, req, flush, hold_fix;
   logic [31:0] lat_pc, lat_pc_n, tgt, alt_q, hold_pc;
   logic [CW-1:0] cnt, cnt_n;
   // An older fix arriving while a pred is held replaces it; a second fix never does.
   assign hold_fix = lat_fix | fix_req_ID;
   assign hold_pc = (fix_req_ID && !lat_fix) ? fix_pc_ID : lat_pc;
   always_comb begin
      state_n = state;
      lat_v_n = lat_v;
      lat_fix_n = lat_fix;
      lat_pc_n = lat_pc;
      cnt_n = cnt;
      req = 1'b0;
      flush = 1'b0;
      tgt = lat_pc;
      case (state)
         IDLE:
            if (!STALL && fix_req_ID) begin
               req = 1'b1;
               flush = 1'b1;
               tgt = fix_pc_ID;
               cnt_n = CW'(DRAIN_CYCLES);
               state_n = DRAIN;
            end else if (!STALL && pred_req_IF) begin
               req = 1'b1;
               tgt = pred_pc_IF;
            end else if (fix_req_ID || pred_req_IF) begin
               lat_fix_n = fix_req_ID;
               lat_pc_n = fix_req_ID ? fix_pc_ID : pred_pc_IF;
               state_n = HOLD;
            end
         HOLD:
            if (STALL) begin
               lat_fix_n = hold_fix;
               lat_pc_n = hold_pc;
            end else begin
               req = 1'b1;
               flush = hold_fix;
               tgt = hold_pc;
               lat_fix_n = 1'b0;
               cnt_n = hold_fix ? CW'(DRAIN_CYCLES) : cnt;
               state_n = hold_fix ? DRAIN : IDLE;
            end
         DRAIN:
            // fix_req_ID here belongs to a squashed slot and is dropped.
            if (!STALL) begin
               cnt_n = cnt - CW'(1);
               state_n = (cnt <= CW'(1)) ? IDLE : DRAIN;
               req = lat_v | pred_req_IF;
               tgt = lat_v ? lat_pc : pred_pc_IF;
               lat_v_n = 1'b0;
            end else if (pred_req_IF && !lat_v) begin
               lat_v_n = 1'b1;
               lat_pc_n = pred_pc_IF;
            end
         default: state_n = IDLE;
      endcase
   end
   assign Request_Alt_PC_OUT = req & ~RESET;
   assign FLUSH_OUT = flush & ~RESET;
   assign Alt_PC_OUT = Request_Alt_PC_OUT ? (tgt & 32'hFFFF_FFFC) : alt_q;
   assign busy = !RESET && state != IDLE;
   always_ff @(posedge CLK)
      if (RESET) begin
         state <= IDLE;
         lat_v <= 1'b0;
         lat_fix <= 1'b0;
         lat_pc <= '0;
         cnt <= '0;
         alt_q <= '0;
      end else begin
         state <= state_n;
         lat_v <= lat_v_n;
         lat_fix <= lat_fix_n;
         lat_pc <= lat_pc_n;
         cnt <= cnt_n;
         alt_q <= Alt_PC_OUT;
      end
`ifdef REDIRECT_STATS_EN
   logic [31:0] pred_cnt, fix_cnt;
   always_ff @(posedge CLK)
      if (RESET) begin
         pred_cnt <= '0;
         fix_cnt <= '0;
      end else begin
         if (Request_Alt_PC_OUT && !FLUSH_OUT && pred_cnt != '1) pred_cnt <= pred_cnt + 32'd1;
         if (FLUSH_OUT && fix_cnt != '1) fix_cnt <= fix_cnt + 32'd1;
      end
   assign pred_count = RESET ? '0 : pred_cnt;
   assign fix_count = RESET ? '0 : fix_cnt;
`else
   assign pred_count = '0;
   assign fix_count = '0;
`endif
endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// tb_pc_redirect_ctrl: directed scenarios plus random traffic against a queue-based redirect model.
module tb_pc_redirect_ctrl;
   localparam int N = 7;
   logic CLK = 1'b0, RESET = 1'b1, STALL = 1'b0, pred_req_IF = 1'b0, fix_req_ID = 1'b0;
   logic [31:0] pred_pc_IF = '0, fix_pc_ID = '0;
   logic Request_Alt_PC_OUT, FLUSH_OUT, busy;
   logic [31:0] Alt_PC_OUT, pred_count, fix_count;
   int total = 0, bad = 0;
   always #5 CLK = ~CLK;
   pc_redirect_ctrl #(.DRAIN_CYCLES(N)) dut (
      .CLK(CLK), .RESET(RESET), .STALL(STALL),
      .pred_req_IF(pred_req_IF), .pred_pc_IF(pred_pc_IF),
      .fix_req_ID(fix_req_ID), .fix_pc_ID(fix_pc_ID),
      .Request_Alt_PC_OUT(Request_Alt_PC_OUT), .Alt_PC_OUT(Alt_PC_OUT),
      .FLUSH_OUT(FLUSH_OUT), .busy(busy),
      .pred_count(pred_count), .fix_count(fix_count)
   );
   typedef struct {logic [31:0] pc; bit fix;} redir_t;
   redir_t pend[$];
   int drain_left = 0;
   logic [31:0] last_pc = '0, e_pc;
   bit e_req, e_flush, e_busy;
   // Model: a pending-redirect queue plus remaining unstalled drain slots.
   task automatic tick(input bit rst, input bit st, input bit pr, input logic [31:0] ppc,
                       input bit fr, input logic [31:0] fpc);
      redir_t r;
      bit go = 0;
      @(posedge CLK);
      #1;
      RESET = rst; STALL = st; pred_req_IF = pr; pred_pc_IF = ppc; fix_req_ID = fr; fix_pc_ID = fpc;
      @(negedge CLK);
      e_busy = !rst && (drain_left > 0 || pend.size() > 0);
      if (rst) begin
         e_req = 0; e_flush = 0; e_pc = last_pc;
         pend.delete(); drain_left = 0; last_pc = '0;
         return;
      end
      if (drain_left > 0) begin
         if (!st) begin
            drain_left--;
            if (pend.size() > 0) begin r = pend.pop_front(); go = 1; end
            else if (pr) begin r.pc = ppc; r.fix = 0; go = 1; end
         end else if (pr && pend.size() == 0) begin
            r.pc = ppc; r.fix = 0; pend.push_back(r);
         end
      end else if (pend.size() > 0) begin
         if (fr && !pend[0].fix) begin pend[0].pc = fpc; pend[0].fix = 1; end
         if (!st) begin r = pend.pop_front(); go = 1; end
      end else if (fr || pr) begin
         r.pc = fr ? fpc : ppc; r.fix = fr;
         if (st) pend.push_back(r); else go = 1;
      end
      if (go && r.fix) drain_left = N;
      if (go) last_pc = r.pc & 32'hFFFF_FFFC;
      e_req = go; e_flush = go && r.fix; e_pc = last_pc;
   endtask
   task automatic test_reset();
      tick(1, 0, 1, 32'h44, 1, 32'h88);
      tick(1, 1, 1, 32'h44, 0, 32'h0);
      total++;
      if (Request_Alt_PC_OUT !== 1'b0 || FLUSH_OUT !== 1'b0 || busy !== 1'b0 || Alt_PC_OUT !== 32'h0) begin
         bad++; $display("FAIL reset: req=%b flush=%b busy=%b pc=%h, want 0 0 0 0", Request_Alt_PC_OUT, FLUSH_OUT, busy, Alt_PC_OUT);
      end
      total++;
      if (pred_count !== 32'h0 || fix_count !== 32'h0) begin
         bad++; $display("FAIL reset_counts: pred=%h fix=%h, want 0 0", pred_count, fix_count);
      end
   endtask
   task automatic test_pred();
      tick(0, 0, 1, 32'h0040_0100, 0, 32'h0);
      total++;
      if (Request_Alt_PC_OUT !== 1'b1 || FLUSH_OUT !== 1'b0 || Alt_PC_OUT !== 32'h0040_0100) begin
         bad++; $display("FAIL pred: req=%b flush=%b pc=%h, want 1 0 00400100", Request_Alt_PC_OUT, FLUSH_OUT, Alt_PC_OUT);
      end
      tick(0, 0, 0, 32'h0, 0, 32'h0);
      total++;
      if (Request_Alt_PC_OUT !== 1'b0 || busy !== 1'b0 || Alt_PC_OUT !== 32'h0040_0100) begin
         bad++; $display("FAIL pred_after: req=%b busy=%b pc=%h, want 0 0 00400100", Request_Alt_PC_OUT, busy, Alt_PC_OUT);
      end
      tick(0, 0, 1, 32'h0040_0107, 0, 32'h0);
      total++;
      if (Request_Alt_PC_OUT !== 1'b1 || Alt_PC_OUT !== 32'h0040_0104) begin
         bad++; $display("FAIL pred_align: req=%b pc=%h, want 1 00400104", Request_Alt_PC_OUT, Alt_PC_OUT);
      end
   endtask
   task automatic test_fix_priority();
      int hi = 0;
      tick(0, 0, 1, 32'h0040_0300, 1, 32'h0040_0200);
      total++;
      if (Request_Alt_PC_OUT !== 1'b1 || FLUSH_OUT !== 1'b1 || Alt_PC_OUT !== 32'h0040_0200) begin
         bad++; $display("FAIL fix_prio: req=%b flush=%b pc=%h, want 1 1 00400200", Request_Alt_PC_OUT, FLUSH_OUT, Alt_PC_OUT);
      end
      for (int i = 0; i < N; i++) begin
         tick(0, 0, 0, 32'h0, 0, 32'h0);
         if (busy === 1'b1 && FLUSH_OUT === 1'b0 && Request_Alt_PC_OUT === 1'b0) hi++;
      end
      tick(0, 0, 0, 32'h0, 0, 32'h0);
      total++;
      if (hi != N || busy !== 1'b0) begin
         bad++; $display("FAIL fix_drain: busy_quiet_cycles=%0d busy_end=%b, want %0d 0", hi, busy, N);
      end
   endtask
   task automatic test_stall_hold();
      int strobes = 0;
      tick(0, 1, 1, 32'h10, 0, 32'h0);
      strobes += Request_Alt_PC_OUT;
      tick(0, 1, 0, 32'h0, 1, 32'h20);
      strobes += Request_Alt_PC_OUT;
      tick(0, 1, 0, 32'h0, 0, 32'h0);
      strobes += Request_Alt_PC_OUT;
      total++;
      if (strobes != 0 || busy !== 1'b1) begin
         bad++; $display("FAIL hold_quiet: strobes=%0d busy=%b, want 0 1", strobes, busy);
      end
      tick(0, 0, 0, 32'h0, 0, 32'h0);
      total++;
      if (Request_Alt_PC_OUT !== 1'b1 || FLUSH_OUT !== 1'b1 || Alt_PC_OUT !== 32'h20) begin
         bad++; $display("FAIL hold_issue: req=%b flush=%b pc=%h, want 1 1 00000020", Request_Alt_PC_OUT, FLUSH_OUT, Alt_PC_OUT);
      end
      tick(0, 0, 0, 32'h0, 0, 32'h0);
      total++;
      if (Request_Alt_PC_OUT !== 1'b0 || FLUSH_OUT !== 1'b0) begin
         bad++; $display("FAIL hold_single: req=%b flush=%b, want 0 0", Request_Alt_PC_OUT, FLUSH_OUT);
      end
      for (int i = 0; i < N; i++) tick(0, 0, 0, 32'h0, 0, 32'h0);
   endtask
   task automatic test_drain();
      int n = 0;
      tick(0, 0, 0, 32'h0, 1, 32'h100);
      tick(0, 0, 0, 32'h0, 1, 32'h40);
      total++;
      if (Request_Alt_PC_OUT !== 1'b0 || FLUSH_OUT !== 1'b0 || Alt_PC_OUT !== 32'h100) begin
         bad++; $display("FAIL drain_fix_ignored: req=%b flush=%b pc=%h, want 0 0 00000100", Request_Alt_PC_OUT, FLUSH_OUT, Alt_PC_OUT);
      end
      n += busy;
      tick(0, 0, 0, 32'h0, 0, 32'h0);
      n += busy;
      for (int i = 0; i < 3; i++) begin
         tick(0, 1, 0, 32'h0, 0, 32'h0);
         n += busy;
      end
      for (int i = 0; i < 20 && busy; i++) begin
         tick(0, 0, 0, 32'h0, 0, 32'h0);
         n += busy;
      end
      total++;
      if (n != N + 3 || busy !== 1'b0) begin
         bad++; $display("FAIL drain_stall: busy_cycles=%0d busy_end=%b, want %0d 0", n, busy, N + 3);
      end
   endtask
   task automatic test_reset_hold();
      tick(0, 1, 0, 32'h0, 1, 32'h500);
      tick(1, 0, 0, 32'h0, 0, 32'h0);
      tick(0, 0, 0, 32'h0, 0, 32'h0);
      total++;
      if (Request_Alt_PC_OUT !== 1'b0 || FLUSH_OUT !== 1'b0 || busy !== 1'b0 || Alt_PC_OUT !== 32'h0 ||
          pred_count !== 32'h0 || fix_count !== 32'h0) begin
         bad++; $display("FAIL reset_hold: req=%b flush=%b busy=%b pc=%h cnt=%h/%h, want all 0",
                         Request_Alt_PC_OUT, FLUSH_OUT, busy, Alt_PC_OUT, pred_count, fix_count);
      end
   endtask
   task automatic test_stats();
      tick(1, 0, 0, 32'h0, 0, 32'h0);
      tick(0, 0, 1, 32'h1000, 0, 32'h0);
      tick(0, 0, 1, 32'h1004, 0, 32'h0);
      tick(0, 0, 0, 32'h0, 1, 32'h2000);
      tick(0, 0, 0, 32'h0, 0, 32'h0);
`ifdef REDIRECT_STATS_EN
      total++;
      if (pred_count !== 32'd2 || fix_count !== 32'd1) begin
         bad++; $display("FAIL stats: pred=%0d fix=%0d, want 2 1", pred_count, fix_count);
      end
      for (int i = 0; i < N; i++) tick(0, 0, 0, 32'h0, 0, 32'h0);
      dut.pred_cnt = '1;
      dut.fix_cnt = '1;
      tick(0, 0, 1, 32'h3000, 0, 32'h0);
      tick(0, 0, 0, 32'h0, 1, 32'h4000);
      tick(0, 0, 0, 32'h0, 0, 32'h0);
      total++;
      if (pred_count !== 32'hFFFF_FFFF || fix_count !== 32'hFFFF_FFFF) begin
         bad++; $display("FAIL stats_sat: pred=%h fix=%h, want ffffffff ffffffff", pred_count, fix_count);
      end
`else
      total++;
      if (pred_count !== 32'h0 || fix_count !== 32'h0) begin
         bad++; $display("FAIL stats_off: pred=%h fix=%h, want 0 0", pred_count, fix_count);
      end
`endif
   endtask
   task automatic test_random();
      for (int i = 0; i < 800; i++) begin
         tick($urandom_range(63) == 0, $urandom_range(2) == 0, $urandom_range(2) == 0, $urandom,
              $urandom_range(4) == 0, $urandom);
         total++;
         if (Request_Alt_PC_OUT !== e_req || FLUSH_OUT !== e_flush || Alt_PC_OUT !== e_pc || busy !== e_busy) begin
            bad++; $display("FAIL random[%0d]: req=%b flush=%b pc=%h busy=%b, want %b %b %h %b", i,
                            Request_Alt_PC_OUT, FLUSH_OUT, Alt_PC_OUT, busy, e_req, e_flush, e_pc, e_busy);
         end
      end
   endtask
   initial begin
      test_reset();
      test_pred();
      test_fix_priority();
      test_stall_hold();
      test_drain();
      test_reset_hold();
      test_stats();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/pc_redirect_ctrl.md
PC_REDIRECT_CTRL -- requirements
Module: pc_redirect_ctrl

Interface
REQ-001 The block SHALL have parameter DRAIN_CYCLES, default 7, giving the number of front-end stage registers (IF through ID) squashed by a fix.
REQ-002 CLK  in  1  sole clock, rising edge.
REQ-003 RESET  in  1  synchronous, active-high reset.
REQ-004 STALL  in  1  front-end freeze from ID; no redirect is issued while high.
REQ-005 pred_req_IF  in  1  BTB predicts taken for the instruction in IF.
REQ-006 pred_pc_IF  in  32  BTB predicted target.
REQ-007 fix_req_ID  in  1  ID resolved a misprediction.
REQ-008 fix_pc_ID  in  32  corrected PC from ID.
REQ-009 Request_Alt_PC_OUT  out  1  one-cycle redirect strobe to IF.
REQ-010 Alt_PC_OUT  out  32  redirect target; valid when strobe is high.
REQ-011 FLUSH_OUT  out  1  one-cycle squash of all front-end stage registers.
REQ-012 busy  out  1  high in HOLD or DRAIN.
REQ-013 pred_count, fix_count  out  32 each  redirect statistics (see Configuration).

Function
REQ-014 The FSM SHALL have the states IDLE, HOLD and DRAIN.
REQ-015 Priority: a fix SHALL win over a prediction in the same cycle, because the fix belongs to the older instruction.
REQ-016 IDLE, STALL=0, fix_req_ID=1: the block SHALL raise Request_Alt_PC_OUT and FLUSH_OUT combinationally that cycle with Alt_PC_OUT=fix_pc_ID, load the drain counter with DRAIN_CYCLES, and go to DRAIN.
REQ-017 IDLE, STALL=0, pred only: the block SHALL raise Request_Alt_PC_OUT with Alt_PC_OUT=pred_pc_IF, keep FLUSH_OUT=0, and stay in IDLE.
REQ-018 IDLE, STALL=1, any request: the block SHALL latch the PC and the kind (fix or pred), keep the strobe low, and go to HOLD.
REQ-019 HOLD: a fix arriving while the latched kind is pred SHALL overwrite the latch; a pred arriving while the latch holds anything SHALL be ignored; a repeated fix SHALL keep the first latched value.
REQ-020 HOLD with STALL=0: the block SHALL issue the latched redirect in that cycle, with FLUSH_OUT=1 only if the kind is fix, then go to DRAIN for a fix or to IDLE for a pred.
REQ-021 DRAIN: fix_req_ID SHALL be ignored because it comes from a squashed slot, and pred_req_IF SHALL be handled as in IDLE (REQ-017 and REQ-018, but the state stays DRAIN if STALL=0).
REQ-022 The drain counter SHALL decrement only on cycles with STALL=0, and the block SHALL return to IDLE the cycle after it reaches 0.
REQ-023 A pred latched during DRAIN under STALL SHALL be held, and issued when STALL falls, without leaving DRAIN early.
REQ-024 Alt_PC_OUT bits [1:0] SHALL always be driven 0, whatever the input alignment.
REQ-025 When the strobe is low, Alt_PC_OUT SHALL hold its last issued value.
REQ-026 Request_Alt_PC_OUT and FLUSH_OUT SHALL never be high for two consecutive cycles as a result of a single request.

Reset
REQ-027 With RESET high at a clock edge, the state SHALL become IDLE, the latch and drain counter SHALL clear, and Alt_PC_OUT SHALL become 0.
REQ-028 During reset, Request_Alt_PC_OUT=0, FLUSH_OUT=0, busy=0, pred_count=0 and fix_count=0.
REQ-029 Reset in HOLD or DRAIN SHALL discard any pending redirect, so no strobe occurs after reset.
REQ-030 Requests present in the reset cycle SHALL be ignored.

Configuration
REQ-031 With REDIRECT_STATS_EN defined, pred_count and fix_count SHALL each increment once per issued pred and fix redirect respectively, and saturate at 0xFFFFFFFF.
REQ-032 Without REDIRECT_STATS_EN, both count outputs SHALL be constant 0 and no counter flops SHALL be inferred.

Verification
REQ-033 Idle, pred_req_IF=1 with pred_pc_IF=0x00400100 for one cycle -> strobe=1 with Alt_PC_OUT=0x00400100 that cycle, FLUSH_OUT=0, busy=0 after.
REQ-034 fix_req_ID and pred_req_IF together (0x00400200 / 0x00400300), STALL=0 -> Alt_PC_OUT=0x00400200, FLUSH_OUT=1, busy=1 for 7 unstalled cycles, then 0.
REQ-035 STALL=1 for 3 cycles with pred 0x10 then fix 0x20 during the stall -> no strobe while stalled; one strobe to 0x20 with FLUSH_OUT=1 on the first STALL=0 cycle.
REQ-036 During DRAIN, fix_req_ID=1 with 0x40 -> no strobe; a STALL pulse mid-drain extends busy by exactly the stalled cycles.
REQ-037 RESET asserted while in HOLD with a pending fix -> no strobe after reset; all outputs 0.
REQ-038 With REDIRECT_STATS_EN, 2 preds and 1 fix issued -> pred_count=2, fix_count=1; with the counters preloaded to 0xFFFFFFFF, they stay there; without the macro, both read 0.
